// File: rtl/fifo_stream_checker.sv
// rtl/fifo_stream_checker.sv - read-side FIFO consumer that checks popped words against an incrementing or LFSR sequence
module fifo_stream_checker #(
    parameter int BITS  = 32,
    parameter int CNT_W = 16,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [BITS-1:0]  seed,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
    output logic             p_read_en,
    input  logic [BITS-1:0]  p_read_data,
    input  logic             p_read_empty,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [BITS-1:0]  first_err_exp,
    output logic [BITS-1:0]  first_err_got
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    // Galois tap masks indexed by width; unknown widths fall back to the 32-bit polynomial.
    localparam logic [63:0] TAP_TABLE =
        (BITS == 8)  ? 64'h0000_0000_0000_00B8 :
        (BITS == 16) ? 64'h0000_0000_0000_B400 :
        (BITS == 64) ? 64'hD800_0000_0000_0000 :
                       64'h0000_0000_8020_0003;
    localparam logic [BITS-1:0]  TAP_MASK = TAP_TABLE[BITS-1:0];
    localparam logic [BITS-1:0]  BITS_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;

    state_t state;
    state_t state_nx;

    logic             mode_r;
    logic [CNT_W-1:0] count_r;
    logic [GAP_W-1:0] gap_r;
    logic [CNT_W-1:0] issued;
    logic [GAP_W-1:0] gap_cnt;
    logic             cmp_flag;
    logic [BITS-1:0]  expected;
    logic             launch;

    function automatic logic [BITS-1:0] next_expected(input logic m, input logic [BITS-1:0] cur);
        if (!m)
            return cur + BITS_ONE;
        else if (cur[0])
            return (cur >> 1) ^ TAP_MASK;
        else
            return cur >> 1;
    endfunction

    assign launch    = start && ((state == IDLE) || (state == DONE));
    assign p_read_en = (state == RUN) && !p_read_empty && (issued < count_r) && (gap_cnt == '0);
    assign busy      = (state == RUN) || (state == FLUSH);
    assign done      = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: RUN drains once every requested read is issued, FLUSH covers the last compare.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if ((issued == count_r) && !p_read_en) state_nx = FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    if (start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    // Run parameters, issued-read counter and post-read gap countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= 1'b0;
            count_r <= '0;
            gap_r   <= '0;
            issued  <= '0;
            gap_cnt <= '0;
        end else if (launch) begin
            mode_r  <= mode;
            count_r <= count;
            gap_r   <= gap;
            issued  <= '0;
            gap_cnt <= '0;
        end else if (state == RUN) begin
            if (p_read_en) begin
                issued  <= issued + CNT_ONE;
                gap_cnt <= gap_r;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_ONE;
            end
        end
    end

    // Compare stage: data returns one cycle after an accepted read; record counts and the first mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_flag        <= 1'b0;
            expected        <= '0;
            rx_count        <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
        end else begin
            cmp_flag <= p_read_en;
            if (launch) begin
                expected        <= (mode && (seed == '0)) ? BITS_ONE : seed;
                rx_count        <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_exp   <= '0;
                first_err_got   <= '0;
            end else if (cmp_flag) begin
                rx_count <= rx_count + CNT_ONE;
                if (p_read_data != expected) begin
                    if (err_count != '1)
                        err_count <= err_count + CNT_ONE;
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= rx_count;
                        first_err_exp   <= expected;
                        first_err_got   <= p_read_data;
                    end
                end
                expected <= next_expected(mode_r, expected);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_checker.sv
// tb/tb_fifo_stream_checker.sv - randomized self-checking bench for fifo_stream_checker
module tb_fifo_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] count = '0;
    logic [3:0]  gap = '0;
    logic        p_read_en;
    logic [31:0] p_read_data = '0;
    logic        p_read_empty = 1'b1;
    logic        busy, done, first_err_valid;
    logic [15:0] rx_count, err_count, first_err_idx;
    logic [31:0] first_err_exp, first_err_got;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic [31:0] words[$];
    bit pend = 0;
    bit have_last = 0;
    int rd_cnt = 0, streak = 0, max_streak = 0, gap_req = 0, viol = 0, cyc = 0, last_rd = 0;

    fifo_stream_checker #(.BITS(32), .CNT_W(16), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .count(count), .gap(gap),
        .p_read_en(p_read_en), .p_read_data(p_read_data), .p_read_empty(p_read_empty),
        .busy(busy), .done(done), .rx_count(rx_count), .err_count(err_count),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    // FIFO model and read-side monitor: a read seen before a rising edge pops at the following falling edge.
    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            if (q.size() > 0) p_read_data = q.pop_front();
            pend = 0;
        end
        p_read_empty = (q.size() == 0);
        #1;
        if (p_read_en === 1'b1) begin
            pend = 1;
            rd_cnt++;
            streak++;
            if (streak > max_streak) max_streak = streak;
            if (p_read_empty) viol++;
            if (have_last && (cyc - last_rd) < gap_req + 1) viol++;
            have_last = 1;
            last_rd = cyc;
        end else begin
            streak = 0;
        end
    end

    function automatic logic [31:0] ref_next(input bit m, input logic [31:0] x);
        if (!m) return x + 32'd1;
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    task automatic model_run(input bit m, input logic [31:0] s, input int n, output int e_err,
                             output int e_idx, output logic [31:0] e_exp, output logic [31:0] e_got,
                             output bit e_v);
        logic [31:0] x;
        x = (m && s == 32'd0) ? 32'd1 : s;
        e_err = 0; e_idx = 0; e_exp = '0; e_got = '0; e_v = 0;
        for (int i = 0; i < n; i++) begin
            if (words[i] !== x) begin
                e_err++;
                if (!e_v) begin e_v = 1; e_idx = i; e_exp = x; e_got = words[i]; end
            end
            x = ref_next(m, x);
        end
    endtask

    task automatic clear_tb();
        q.delete(); words.delete();
        rd_cnt = 0; max_streak = 0; viol = 0; have_last = 0; gap_req = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        words.push_back(w);
        q.push_back(w);
    endtask

    task automatic start_run(input bit m, input logic [31:0] s, input int c, input int g);
        @(posedge clk); #1;
        mode = m; seed = s; count = 16'(c); gap = 4'(g); gap_req = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, done, p_read_en, first_err_valid} !== 4'b0) begin n_bad++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, p_read_en, first_err_valid}); end
        n_cmp++; if ({rx_count, err_count, first_err_idx} !== 48'd0) begin n_bad++;
            $display("FAIL reset_counts got %h want 0", {rx_count, err_count, first_err_idx}); end
        n_cmp++; if ({first_err_exp, first_err_got} !== 64'd0) begin n_bad++;
            $display("FAIL reset_first_err got %h want 0", {first_err_exp, first_err_got}); end
        rst = 1'b0;
    endtask

    task automatic test_incrementing();
        bit ok;
        clear_tb();
        for (int i = 0; i < 16; i++) push_word(32'(i));
        start_run(0, 32'd0, 16, 0);
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL inc_done got 0 want 1"); end
        n_cmp++; if (max_streak !== 16) begin n_bad++; $display("FAIL inc_streak got %0d want 16", max_streak); end
        n_cmp++; if (rx_count !== 16'd16) begin n_bad++; $display("FAIL inc_rx got %0d want 16", rx_count); end
        n_cmp++; if ({err_count, first_err_valid} !== 17'd0) begin n_bad++;
            $display("FAIL inc_err got %0d/%b want 0/0", err_count, first_err_valid); end
    endtask

    task automatic test_corrupt();
        bit ok;
        clear_tb();
        for (int i = 0; i < 16; i++) push_word((i == 5) ? 32'hDEAD_BEEF : 32'(i));
        start_run(0, 32'd0, 16, 0);
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL corrupt_done got 0 want 1"); end
        n_cmp++; if ({err_count, first_err_valid, first_err_idx} !== {16'd1, 1'b1, 16'd5}) begin n_bad++;
            $display("FAIL corrupt_err got %0d/%b/%0d want 1/1/5", err_count, first_err_valid, first_err_idx); end
        n_cmp++; if ({first_err_exp, first_err_got} !== {32'd5, 32'hDEAD_BEEF}) begin n_bad++;
            $display("FAIL corrupt_detail got %h/%h want 5/deadbeef", first_err_exp, first_err_got); end
        n_cmp++; if (rx_count !== 16'd16) begin n_bad++; $display("FAIL corrupt_rx got %0d want 16", rx_count); end
    endtask

    task automatic test_lfsr_slow();
        bit ok;
        clear_tb();
        fork
            begin
                logic [31:0] x;
                x = 32'd1;
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(1, 6)) @(posedge clk);
                    #2;
                    push_word(x);
                    x = ref_next(1, x);
                end
            end
            begin
                start_run(1, 32'd1, 1000, 3);
                wait_done(20000, ok);
            end
        join
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL lfsr_done got 0 want 1"); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL lfsr_rule_violations got %0d want 0", viol); end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL lfsr_err got %0d want 0", err_count); end
        n_cmp++; if (rx_count !== 16'd1000) begin n_bad++; $display("FAIL lfsr_rx got %0d want 1000", rx_count); end
        n_cmp++; if (rd_cnt !== 1000) begin n_bad++; $display("FAIL lfsr_reads got %0d want 1000", rd_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_tb();
        push_word(32'hFFFF_FFFE); push_word(32'hFFFF_FFFF); push_word(32'd0); push_word(32'd1);
        start_run(0, 32'hFFFF_FFFE, 4, 0);
        wait_done(100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done got 0 want 1"); end
        n_cmp++; if ({err_count, rx_count} !== {16'd0, 16'd4}) begin n_bad++;
            $display("FAIL wrap_counts got err=%0d rx=%0d want err=0 rx=4", err_count, rx_count); end
    endtask

    task automatic test_count_zero_and_busy();
        bit ok;
        int e_err, e_idx;
        logic [31:0] e_exp, e_got;
        bit e_v;
        clear_tb();
        for (int i = 0; i < 4; i++) push_word(32'(i));
        start_run(0, 32'd0, 0, 0);
        wait_done(3, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL zero_done got 0 want 1 within 3 cycles"); end
        n_cmp++; if ({16'(rd_cnt), rx_count} !== 32'd0) begin n_bad++;
            $display("FAIL zero_reads got reads=%0d rx=%0d want 0/0", rd_cnt, rx_count); end
        clear_tb();
        for (int i = 0; i < 8; i++) push_word(32'd100 + 32'(i));
        push_word(32'd7); push_word(32'd7);
        start_run(0, 32'd100, 8, 2);
        repeat (3) @(posedge clk);
        #1;
        mode = 1'b1; seed = 32'd5; count = 16'd3; gap = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, ok);
        model_run(0, 32'd100, 8, e_err, e_idx, e_exp, e_got, e_v);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_done got 0 want 1"); end
        n_cmp++; if ({rx_count, err_count, 16'(rd_cnt)} !== {16'd8, 16'(e_err), 16'd8}) begin n_bad++;
            $display("FAIL busy_ignore got rx=%0d err=%0d reads=%0d want 8/%0d/8", rx_count, err_count, rd_cnt, e_err); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if ({done, rx_count} !== {1'b1, 16'd8}) begin n_bad++;
            $display("FAIL done_hold got done=%b rx=%0d want 1/8", done, rx_count); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int snap;
        clear_tb();
        for (int i = 0; i < 20; i++) push_word(32'd300 + 32'(i));
        start_run(0, 32'd300, 20, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rd_cnt >= 7) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrun_reach7 got %0d reads want 7", rd_cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done, p_read_en, first_err_valid, rx_count, err_count} !== 36'd0) begin n_bad++;
            $display("FAIL midrun_reset got busy=%b done=%b ren=%b rx=%0d err=%0d want all 0",
                     busy, done, p_read_en, rx_count, err_count); end
        rst = 1'b0;
        @(negedge clk); #2;
        snap = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (rd_cnt !== snap) begin n_bad++; $display("FAIL midrun_no_reads got %0d want %0d", rd_cnt, snap); end
        clear_tb();
        for (int i = 0; i < 10; i++) push_word(32'd50 + 32'(i));
        start_run(0, 32'd50, 10, 1);
        wait_done(200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rerun_done got 0 want 1"); end
        n_cmp++; if ({rx_count, err_count, first_err_valid} !== {16'd10, 16'd0, 1'b0}) begin n_bad++;
            $display("FAIL rerun_result got rx=%0d err=%0d fev=%b want 10/0/0", rx_count, err_count, first_err_valid); end
    endtask

    task automatic test_random();
        bit ok, m, e_v;
        int c, g, e_err, e_idx;
        logic [31:0] s, x, e_exp, e_got;
        for (int it = 0; it < 12; it++) begin
            clear_tb();
            m = 1'($urandom_range(0, 1));
            s = $urandom();
            if (m && $urandom_range(0, 3) == 0) s = 32'd0;
            c = $urandom_range(1, 40);
            g = $urandom_range(0, 3);
            x = (m && s == 32'd0) ? 32'd1 : s;
            for (int i = 0; i < c + 3; i++) begin
                push_word(($urandom_range(0, 7) == 0) ? $urandom() : x);
                x = ref_next(m, x);
            end
            start_run(m, s, c, g);
            wait_done(400, ok);
            model_run(m, s, c, e_err, e_idx, e_exp, e_got, e_v);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_done got 0 want 1", it); end
            n_cmp++; if ({rx_count, err_count, first_err_valid} !== {16'(c), 16'(e_err), e_v}) begin n_bad++;
                $display("FAIL rand%0d_counts got rx=%0d err=%0d fev=%b want %0d/%0d/%b",
                         it, rx_count, err_count, first_err_valid, c, e_err, e_v); end
            if (e_v) begin
                n_cmp++; if ({first_err_idx, first_err_exp, first_err_got} !== {16'(e_idx), e_exp, e_got}) begin n_bad++;
                    $display("FAIL rand%0d_first got %0d/%h/%h want %0d/%h/%h", it, first_err_idx,
                             first_err_exp, first_err_got, e_idx, e_exp, e_got); end
            end
            n_cmp++; if ({viol, rd_cnt} !== {32'd0, 32'(c)}) begin n_bad++;
                $display("FAIL rand%0d_reads got viol=%0d reads=%0d want 0/%0d", it, viol, rd_cnt, c); end
        end
    endtask

    initial begin
        test_reset();
        test_incrementing();
        test_corrupt();
        test_lfsr_slow();
        test_wrap();
        test_count_zero_and_busy();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
